// File: rtl/io_sequence_monitor_if.sv
// Bus bundle for io_sequence_monitor: monitored input, sequence-RAM write port,
// run configuration and status. The harness/bench is master, the monitor is slave.
interface io_sequence_monitor_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT_W = 24
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]     bus_in;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_value;
  logic [WIDTH-1:0]     wr_mask;
  logic [AW:0]          seq_len;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic                 strict;
  logic                 start;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  logic [1:0]           fail_code;
  logic [AW:0]          match_idx;

  modport master (
    output bus_in, wr_en, wr_addr, wr_value, wr_mask,
    output seq_len, timeout_limit, strict, start,
    input  busy, pass, fail, fail_code, match_idx
  );

  modport slave (
    input  bus_in, wr_en, wr_addr, wr_value, wr_mask,
    input  seq_len, timeout_limit, strict, start,
    output busy, pass, fail, fail_code, match_idx
  );
endinterface

// File: rtl/io_sequence_monitor.sv
// Self-check monitor: waits for an ordered sequence of masked values on an
// asynchronous bus and reports pass, or fail with a timeout/order reason code.
module io_sequence_monitor #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_W     = 24,
  parameter int STABLE_CYCLES = 2
) (
  input logic                  CLK,
  input logic                  reset,
  io_sequence_monitor_if.slave mon
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_FULL  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic          SINGLE_CYCLE = (STABLE_CYCLES == 1);
  localparam logic [LW-1:0] DEPTH_LEN    = LW'(DEPTH);
  localparam logic [1:0]    CODE_NONE    = 2'b00;
  localparam logic [1:0]    CODE_TIMEOUT = 2'b01;
  localparam logic [1:0]    CODE_ORDER   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  function automatic logic masked_eq(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] m);
    return ((a ^ b) & m) == {WIDTH{1'b0}};
  endfunction

  logic [WIDTH-1:0]     val_mem  [DEPTH];
  logic [WIDTH-1:0]     mask_mem [DEPTH];

  logic [WIDTH-1:0]     sync1_r, sync2_r, prev_r, qval_r;
  logic [CW-1:0]        cnt_r;
  logic                 qual_r;
  state_t               state_r;
  logic                 busy_r, pass_r, fail_r, strict_r;
  logic [1:0]           code_r;
  logic [LW-1:0]        match_idx_r, len_r;
  logic [TIMEOUT_W-1:0] tcnt_r, lim_r;

  logic                 changed_s, qual_s, hit_cur_s, hit_prv_s, timeout_s;
  logic [AW-1:0]        idx_s, prv_s;
  logic [LW-1:0]        match_nxt_s;

  // Stability qualification, entry compare and timeout detection
  always_comb begin
    changed_s   = (sync2_r != prev_r);
    qual_s      = 1'b0;
    timeout_s   = 1'b0;
    if (changed_s) begin
      qual_s = SINGLE_CYCLE;
    end else begin
      qual_s = (cnt_r == STABLE_LAST);
    end
    idx_s       = match_idx_r[AW-1:0];
    prv_s       = idx_s - AW'(1);
    match_nxt_s = match_idx_r + LW'(1);
    hit_cur_s   = masked_eq(qval_r, val_mem[idx_s], mask_mem[idx_s]);
    hit_prv_s   = (match_idx_r != {LW{1'b0}}) && masked_eq(qval_r, val_mem[prv_s], mask_mem[prv_s]);
    if (lim_r != {TIMEOUT_W{1'b0}}) begin
      timeout_s = (tcnt_r == lim_r - TIMEOUT_W'(1));
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Two-flop synchronizer plus one qualify pulse per newly stable value
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      prev_r  <= {WIDTH{1'b0}};
      qval_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      qual_r  <= 1'b0;
    end else begin
      sync1_r <= mon.bus_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      qual_r  <= qual_s;
      if (qual_s) begin
        qval_r <= sync2_r;
      end
      if (changed_s) begin
        cnt_r <= CW'(1);
      end else if (cnt_r != STABLE_FULL) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Sequence RAM write port, closed while a run is armed
  always_ff @(posedge CLK) begin
    if (mon.wr_en && !busy_r) begin
      val_mem[mon.wr_addr]  <= mon.wr_value;
      mask_mem[mon.wr_addr] <= mon.wr_mask;
    end
  end

  // Control FSM with registered status outputs; start from any state re-arms
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      code_r      <= CODE_NONE;
      match_idx_r <= {LW{1'b0}};
      len_r       <= {LW{1'b0}};
      lim_r       <= {TIMEOUT_W{1'b0}};
      tcnt_r      <= {TIMEOUT_W{1'b0}};
      strict_r    <= 1'b0;
    end else if (mon.start) begin
      lim_r       <= mon.timeout_limit;
      strict_r    <= mon.strict;
      tcnt_r      <= {TIMEOUT_W{1'b0}};
      fail_r      <= 1'b0;
      code_r      <= CODE_NONE;
      match_idx_r <= {LW{1'b0}};
      len_r       <= (mon.seq_len > DEPTH_LEN) ? DEPTH_LEN : mon.seq_len;
      if (mon.seq_len == {LW{1'b0}}) begin
        state_r <= PASS;
        busy_r  <= 1'b0;
        pass_r  <= 1'b1;
      end else begin
        state_r <= ARMED;
        busy_r  <= 1'b1;
        pass_r  <= 1'b0;
      end
    end else begin
      case (state_r)
        ARMED: begin
          if (tcnt_r != {TIMEOUT_W{1'b1}} && lim_r != {TIMEOUT_W{1'b0}}) begin
            tcnt_r <= tcnt_r + TIMEOUT_W'(1);
          end
          // Final match outranks timeout, which outranks an order violation
          if (qual_r && hit_cur_s && match_nxt_s == len_r) begin
            state_r     <= PASS;
            busy_r      <= 1'b0;
            pass_r      <= 1'b1;
            match_idx_r <= match_nxt_s;
          end else if (timeout_s) begin
            state_r <= FAIL;
            busy_r  <= 1'b0;
            fail_r  <= 1'b1;
            code_r  <= CODE_TIMEOUT;
          end else if (qual_r && hit_cur_s) begin
            match_idx_r <= match_nxt_s;
          end else if (qual_r && strict_r && !hit_prv_s) begin
            state_r <= FAIL;
            busy_r  <= 1'b0;
            fail_r  <= 1'b1;
            code_r  <= CODE_ORDER;
          end
        end
        IDLE, PASS, FAIL: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          pass_r  <= 1'b0;
          fail_r  <= 1'b0;
          code_r  <= CODE_NONE;
        end
      endcase
    end
  end

  assign mon.busy      = busy_r;
  assign mon.pass      = pass_r;
  assign mon.fail      = fail_r;
  assign mon.fail_code = code_r;
  assign mon.match_idx = match_idx_r;
endmodule

// File: tb/tb_io_sequence_monitor.sv
// Bench for io_sequence_monitor: table-driven runs, a match_idx scoreboard and
// hand-written timing corner cases; a second instance uses STABLE_CYCLES=4.
module tb_io_sequence_monitor;
  logic CLK;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  io_sequence_monitor_if #(.WIDTH(8), .DEPTH(16), .TIMEOUT_W(24)) a ();
  io_sequence_monitor_if #(.WIDTH(8), .DEPTH(16), .TIMEOUT_W(24)) b ();

  assign b.bus_in        = a.bus_in;
  assign b.wr_en         = a.wr_en;
  assign b.wr_addr       = a.wr_addr;
  assign b.wr_value      = a.wr_value;
  assign b.wr_mask       = a.wr_mask;
  assign b.seq_len       = a.seq_len;
  assign b.timeout_limit = a.timeout_limit;
  assign b.strict        = a.strict;
  assign b.start         = a.start;

  io_sequence_monitor #(.WIDTH(8), .DEPTH(16), .TIMEOUT_W(24), .STABLE_CYCLES(2)) dut (
    .CLK(CLK), .reset(reset), .mon(a)
  );
  io_sequence_monitor #(.WIDTH(8), .DEPTH(16), .TIMEOUT_W(24), .STABLE_CYCLES(4)) dut4 (
    .CLK(CLK), .reset(reset), .mon(b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit         arm;
    logic [4:0] len;
    bit         strict;
    logic [23:0] limit;
    logic [7:0] bus;
    int         hold;
    logic [4:0] e_idx;
    bit         e_busy;
    bit         e_pass;
    bit         e_fail;
    logic [1:0] e_code;
  } vec_t;

  vec_t       tbl [$];
  logic [4:0] sb_q [$];
  logic [4:0] mon_prev = 5'd0;
  logic [7:0] seq_vals [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    a.bus_in = v;
    repeat (n) tick();
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] v, input logic [7:0] m);
    a.wr_en    = 1'b1;
    a.wr_addr  = addr;
    a.wr_value = v;
    a.wr_mask  = m;
    tick();
    a.wr_en    = 1'b0;
  endtask

  task automatic arm(input logic [4:0] len, input logic s, input logic [23:0] lim);
    a.seq_len       = len;
    a.strict        = s;
    a.timeout_limit = lim;
    a.start         = 1'b1;
    tick();
    a.start         = 1'b0;
  endtask

  task automatic status(input string tag, input logic [4:0] idx, input logic bsy,
                        input logic ps, input logic fl, input logic [1:0] code);
    check({tag, "_idx"},  a.match_idx, idx);
    check({tag, "_busy"}, a.busy, bsy);
    check({tag, "_pass"}, a.pass, ps);
    check({tag, "_fail"}, a.fail, fl);
    check({tag, "_code"}, a.fail_code, code);
  endtask

  // Scoreboard: every nonzero change of match_idx must be the next expected value
  always @(negedge CLK) begin
    if (!reset && a.match_idx != mon_prev && a.match_idx != 5'd0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: match_idx=%0d, expected no event", a.match_idx);
      end else begin
        check("sb_match_idx", a.match_idx, sb_q.pop_front());
      end
    end
    mon_prev <= a.match_idx;
  end

  initial begin
    logic [4:0] exp_prev;
    int         lims [3] = '{5, 6, 4};

    reset           = 1'b1;
    a.bus_in        = 8'h00;
    a.wr_en         = 1'b0;
    a.wr_addr       = 4'd0;
    a.wr_value      = 8'h00;
    a.wr_mask       = 8'h00;
    a.seq_len       = 5'd0;
    a.timeout_limit = 24'd0;
    a.strict        = 1'b0;
    a.start         = 1'b0;
    repeat (3) tick();
    status("reset_held", 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    repeat (4) tick();
    status("idle", 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);

    for (int i = 0; i < 12; i++) load(4'(i), seq_vals[i], 8'hFF);

    // Full 12-entry run, then strict order violation, then relaxed order
    for (int i = 0; i < 12; i++)
      tbl.push_back('{(i == 0), 5'd12, 1'b0, 24'd100000, seq_vals[i], 10,
                      5'(i + 1), (i != 11), (i == 11), 1'b0, 2'b00});
    tbl.push_back('{1'b1, 5'd3, 1'b1, 24'd0, 8'h01, 10, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 5'd3, 1'b1, 24'd0, 8'h07, 10, 5'd1, 1'b0, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{1'b1, 5'd3, 1'b0, 24'd0, 8'h01, 10, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 5'd3, 1'b0, 24'd0, 8'h07, 10, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 5'd3, 1'b0, 24'd0, 8'h02, 10, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 5'd3, 1'b0, 24'd0, 8'h03, 10, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00});

    exp_prev = 5'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].arm) begin
        arm(tbl[i].len, tbl[i].strict, tbl[i].limit);
        exp_prev = 5'd0;
      end
      if (tbl[i].e_idx != exp_prev) begin
        sb_q.push_back(tbl[i].e_idx);
        exp_prev = tbl[i].e_idx;
      end
      hold(tbl[i].bus, tbl[i].hold);
      status($sformatf("vec%0d", i), tbl[i].e_idx, tbl[i].e_busy,
             tbl[i].e_pass, tbl[i].e_fail, tbl[i].e_code);
    end
    check("sb_drain_table", sb_q.size(), 0);

    // Timeout after exactly 500 armed cycles, bus stalls after 05
    arm(5'd12, 1'b0, 24'd500);
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(5'(i + 1));
      hold(seq_vals[i], 10);
    end
    repeat (449) tick();
    status("to_499", 5'd5, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    status("to_500", 5'd5, 1'b0, 1'b0, 1'b1, 2'b01);
    check("sb_drain_timeout", sb_q.size(), 0);

    // Final match lands on edge 5 after start: limit 5 ties, 6 is late, 4 is early
    for (int k = 0; k < 3; k++) begin
      hold(8'h00, 8);
      arm(5'd1, 1'b0, 24'(lims[k]));
      if (lims[k] >= 5) sb_q.push_back(5'd1);
      hold(8'h01, 8);
      if (lims[k] >= 5)
        status($sformatf("tie_lim%0d", lims[k]), 5'd1, 1'b0, 1'b1, 1'b0, 2'b00);
      else
        status($sformatf("tie_lim%0d", lims[k]), 5'd0, 1'b0, 1'b0, 1'b1, 2'b01);
    end
    check("sb_drain_tie", sb_q.size(), 0);
    arm(5'd0, 1'b0, 24'd0);
    status("len0", 5'd0, 1'b0, 1'b1, 1'b0, 2'b00);

    // Debounce: a 3-cycle glitch qualifies at STABLE_CYCLES=2 but not at 4
    load(4'd1, 8'hF5, 8'h0F);
    load(4'd2, 8'h05, 8'h0F);
    hold(8'h00, 8);
    arm(5'd3, 1'b0, 24'd0);
    sb_q.push_back(5'd1);
    hold(8'h01, 3);
    hold(8'h00, 3);
    check("glitch_s2_idx", a.match_idx, 5'd1);
    check("glitch_s4_idx", b.match_idx, 5'd0);
    hold(8'h00, 3);
    hold(8'h01, 10);
    check("held_s4_idx", b.match_idx, 5'd1);
    sb_q.push_back(5'd2);
    hold(8'hA5, 10);
    check("mask_a5_s4_idx", b.match_idx, 5'd2);
    sb_q.push_back(5'd3);
    hold(8'h35, 10);
    status("mask_35", 5'd3, 1'b0, 1'b1, 1'b0, 2'b00);
    check("mask_35_s4_pass", b.pass, 1'b1);
    check("sb_drain_glitch", sb_q.size(), 0);

    // Write while busy is dropped; start while armed restarts the run
    hold(8'h00, 8);
    arm(5'd12, 1'b0, 24'd0);
    sb_q.push_back(5'd1);
    hold(8'h01, 10);
    status("pre_restart", 5'd1, 1'b1, 1'b0, 1'b0, 2'b00);
    load(4'd0, 8'h55, 8'hFF);
    hold(8'h00, 8);
    arm(5'd1, 1'b0, 24'd0);
    status("restart", 5'd0, 1'b1, 1'b0, 1'b0, 2'b00);
    sb_q.push_back(5'd1);
    hold(8'h01, 10);
    status("wr_ignored", 5'd1, 1'b0, 1'b1, 1'b0, 2'b00);
    check("sb_drain_restart", sb_q.size(), 0);

    // Asynchronous reset in the middle of an armed run
    hold(8'h00, 8);
    arm(5'd12, 1'b0, 24'd0);
    sb_q.push_back(5'd1);
    hold(8'h01, 10);
    status("pre_reset", 5'd1, 1'b1, 1'b0, 1'b0, 2'b00);
    #2;
    reset = 1'b1;
    #1;
    status("async_reset", 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge CLK);
    reset = 1'b0;
    repeat (3) tick();
    status("post_reset", 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    check("sb_drain_reset", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
